// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the CAM command front end
// Purpose: op and FSM state enums plus the queued command record.
// Ports: none (package).
package cam_pkg;

   localparam int WIDTH      = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int DEPTH      = 4;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_READ   = 2'b01,
      OP_WRITE  = 2'b10,
      OP_SEARCH = 2'b11
   } cam_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } cam_fe_state_e;

   typedef struct packed {
      cam_op_e               op;
      logic [ADDR_WIDTH-1:0] index;
      logic [WIDTH-1:0]      data;
   } cam_cmd_t;

endpackage

// File: rtl/cam_frontend_if.sv
// rtl/cam_frontend_if.sv - command, CAM and response signals of the front end
// Purpose: bundles the command channel, the CAM strobe/result buses and the
//    response channel.
// Modports: master = producer/CAM/consumer side, slave = cam_frontend side.
interface cam_frontend_if
   import cam_pkg::*;
#(
   parameter int WIDTH      = cam_pkg::WIDTH,
   parameter int ADDR_WIDTH = cam_pkg::ADDR_WIDTH
);
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [1:0]            cmd_op_i;
   logic [ADDR_WIDTH-1:0] cmd_index_i;
   logic [WIDTH-1:0]      cmd_data_i;
   logic                  read_enable_o;
   logic                  write_enable_o;
   logic                  search_enable_o;
   logic [ADDR_WIDTH-1:0] read_index_o;
   logic [ADDR_WIDTH-1:0] write_index_o;
   logic [WIDTH-1:0]      write_data_o;
   logic [WIDTH-1:0]      search_data_o;
   logic                  read_valid_i;
   logic [WIDTH-1:0]      read_value_i;
   logic                  search_valid_i;
   logic [ADDR_WIDTH-1:0] search_index_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [1:0]            rsp_op_o;
   logic                  rsp_hit_o;
   logic [WIDTH-1:0]      rsp_data_o;

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_index_i, cmd_data_i,
      output read_valid_i, read_value_i, search_valid_i, search_index_i, rsp_ready_i,
      input  cmd_ready_o, read_enable_o, write_enable_o, search_enable_o,
      input  read_index_o, write_index_o, write_data_o, search_data_o,
      input  rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_data_o
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_index_i, cmd_data_i,
      input  read_valid_i, read_value_i, search_valid_i, search_index_i, rsp_ready_i,
      output cmd_ready_o, read_enable_o, write_enable_o, search_enable_o,
      output read_index_o, write_index_o, write_data_o, search_data_o,
      output rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_data_o
   );
endinterface

// File: rtl/cam_cmd_fifo.sv
// rtl/cam_cmd_fifo.sv - synchronous command FIFO in front of the CAM issue FSM
// Purpose: DEPTH-entry FIFO of cam_cmd_t with a show-ahead head.
// Ports: clk_i/rst_i; push/push_cmd write side; pop/head read side; full/empty.
module cam_cmd_fifo
   import cam_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push,
   input  cam_cmd_t push_cmd,
   input  logic     pop,
   output cam_cmd_t head,
   output logic     full,
   output logic     empty
);
   localparam int PW = $clog2(DEPTH);

   // Extra MSB is the wrap bit: equal pointers = empty, differing only in
   // the wrap bit = full.
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   cam_cmd_t    mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   // A push while full is dropped: the producer ignored cmd_ready.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head    = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= push_cmd;
   end
endmodule

// File: rtl/cam_frontend.sv
// rtl/cam_frontend.sv - in-order CAM command front end with one command in flight
// Purpose: buffers commands, issues them to the CAM one at a time, captures the
//    result the cycle after the strobe and returns an in-order response.
// Ports: clk_i (rising edge), rst_i (async, active high), bus (slave modport:
//    command channel, CAM strobes/results, response channel).
module cam_frontend
   import cam_pkg::*;
#(
   parameter int WIDTH      = cam_pkg::WIDTH,
   parameter int ADDR_WIDTH = cam_pkg::ADDR_WIDTH,
   parameter int DEPTH      = cam_pkg::DEPTH
) (
   input  logic           clk_i,
   input  logic           rst_i,
   cam_frontend_if.slave  bus
);
   cam_fe_state_e    state;
   cam_fe_state_e    state_next;
   cam_cmd_t         enq_cmd;
   cam_cmd_t         head;
   cam_cmd_t         issue;
   logic             full;
   logic             empty;
   logic             pop;
   cam_op_e          rsp_op;
   logic             rsp_hit;
   logic [WIDTH-1:0] rsp_data;

   assign enq_cmd = '{op: cam_op_e'(bus.cmd_op_i), index: bus.cmd_index_i, data: bus.cmd_data_i};

   cam_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push     (bus.cmd_valid_i),
      .push_cmd (enq_cmd),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next          = state;
      pop                 = 1'b0;
      bus.read_enable_o   = 1'b0;
      bus.write_enable_o  = 1'b0;
      bus.search_enable_o = 1'b0;
      bus.rsp_valid_o     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               // NOP never touches the CAM, so it skips straight to RESP.
               state_next = (head.op == OP_NOP) ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bus.read_enable_o   = (issue.op == OP_READ);
            bus.write_enable_o  = (issue.op == OP_WRITE);
            bus.search_enable_o = (issue.op == OP_SEARCH);
            state_next          = ST_WAIT;
         end
         ST_WAIT: state_next = ST_RESP;
         ST_RESP: begin
            bus.rsp_valid_o = 1'b1;
            if (bus.rsp_ready_i) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Response registers only change on a pop or in WAIT, so the payload is
   // frozen for the whole RESP stall.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         issue    <= '0;
         rsp_op   <= OP_NOP;
         rsp_hit  <= 1'b0;
         rsp_data <= '0;
      end else begin
         if (pop) begin
            issue <= head;
            if (head.op == OP_NOP) begin
               rsp_op   <= OP_NOP;
               rsp_hit  <= 1'b0;
               rsp_data <= '0;
            end
         end
         if (state == ST_WAIT) begin
            rsp_op <= issue.op;
            case (issue.op)
               OP_READ: begin
                  rsp_hit  <= bus.read_valid_i;
                  rsp_data <= bus.read_value_i;
               end
               OP_SEARCH: begin
                  rsp_hit  <= bus.search_valid_i;
                  rsp_data <= {{(WIDTH-ADDR_WIDTH){1'b0}}, bus.search_index_i};
               end
               OP_WRITE: begin
                  rsp_hit  <= 1'b1;
                  rsp_data <= '0;
               end
               default: begin
                  rsp_hit  <= 1'b0;
                  rsp_data <= '0;
               end
            endcase
         end
      end
   end

   assign bus.cmd_ready_o   = !full;
   assign bus.read_index_o  = issue.index;
   assign bus.write_index_o = issue.index;
   assign bus.write_data_o  = issue.data;
   assign bus.search_data_o = issue.data;
   assign bus.rsp_op_o      = rsp_op;
   assign bus.rsp_hit_o     = rsp_hit;
   assign bus.rsp_data_o    = rsp_data;
endmodule
